systolic_job_ctrl: RTL and testbench

//  Initiator/host side of the 8x8 systolic array start/done protocol.
//  - Fills A and B (8x8 signed) from a valid/ready word stream.
//  - Raises sa_start and holds it until sa_done, then captures C and drops sa_start so the array returns to idle.
//  - Streams the 64 C results out on a valid/ready port.

---
 rtl/systolic_job_ctrl_if.sv | 25 ++
 rtl/systolic_job_ctrl.sv | 117 +++++++++++
 tb/tb_systolic_job_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_job_ctrl_if.sv
// Word-stream bundle between the DMA/stream fabric and the systolic job controller.
// Handshake: a word moves only on a rising clk edge where valid && ready; the
// source holds data/last stable while valid is high and ready is low.
interface systolic_job_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_data;
  logic                  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/systolic_job_ctrl.sv
// Host-side job controller for an 8x8 systolic array: loads A/B from a word
// stream, runs one start/done handshake under a watchdog, then streams C out.
module systolic_job_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  systolic_job_ctrl_if.slave                  bus,
  output logic                                busy,
  output logic                                err,
  output logic                                sa_start,
  output logic [7:0][7:0][DATA_WIDTH-1:0]     sa_A_matrix,
  output logic [7:0][7:0][DATA_WIDTH-1:0]     sa_B_matrix,
  input  logic [7:0][7:0][ACC_WIDTH-1:0]      sa_C,
  input  logic                                sa_done,
  output logic [2:0]                          dbg_state
);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    RUN     = 3'd2,
    RELEASE = 3'd3,
    UNLOAD  = 3'd4
  } state_t;

  state_t                          state;
  state_t                          state_next;
  logic [5:0]                      cnt;
  logic [WD_W-1:0]                 wd;
  logic                            abort;
  logic [7:0][7:0][DATA_WIDTH-1:0] a_mem;
  logic [7:0][7:0][DATA_WIDTH-1:0] b_mem;
  logic [7:0][7:0][ACC_WIDTH-1:0]  c_mem;
  logic                            in_fire;
  logic                            out_fire;
  logic                            last_word;
  logic                            timeout_hit;

  assign in_fire     = bus.in_valid && bus.in_ready;
  assign out_fire    = bus.out_valid && bus.out_ready;
  assign last_word   = (cnt == 6'd63);
  assign timeout_hit = (state == RUN) && !sa_done && (wd == WD_LAST);

  assign sa_A_matrix = a_mem;
  assign sa_B_matrix = b_mem;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_A;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD_A:  if (in_fire && last_word) state_next = LOAD_B;
      LOAD_B:  if (in_fire && last_word) state_next = RUN;
      RUN:     if (sa_done || timeout_hit) state_next = RELEASE;
      RELEASE: if (!sa_done) state_next = abort ? LOAD_A : UNLOAD;
      UNLOAD:  if (out_fire && last_word) state_next = LOAD_A;
      default: state_next = LOAD_A;
    endcase
  end

  // Every output is a decode of registered state, so sa_start cannot glitch.
  always_comb begin
    bus.in_ready  = !rst && ((state == LOAD_A) || (state == LOAD_B));
    bus.out_valid = (state == UNLOAD);
    bus.out_last  = (state == UNLOAD) && last_word;
    bus.out_data  = c_mem[cnt[5:3]][cnt[2:0]];
    sa_start      = (state == RUN);
    busy          = !((state == LOAD_A) && (cnt == 6'd0));
    dbg_state     = state;
  end

  // The shared 6-bit counter rolls to 0 exactly on the 64th transfer, which is
  // also the edge that leaves the phase, so each phase starts at index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      wd    <= '0;
      abort <= 1'b0;
      err   <= 1'b0;
      a_mem <= '0;
      b_mem <= '0;
      c_mem <= '0;
    end else begin
      wd <= '0;
      case (state)
        LOAD_A: if (in_fire) begin
          a_mem[cnt[5:3]][cnt[2:0]] <= bus.in_data;
          cnt <= cnt + 6'd1;
        end
        LOAD_B: if (in_fire) begin
          b_mem[cnt[5:3]][cnt[2:0]] <= bus.in_data;
          cnt <= cnt + 6'd1;
        end
        RUN: begin
          wd <= wd + WD_W'(1);
          if (sa_done) begin
            c_mem <= sa_C;
          end else if (timeout_hit) begin
            err   <= 1'b1;
            abort <= 1'b1;
          end
        end
        RELEASE: if (!sa_done) abort <= 1'b0;
        UNLOAD:  if (out_fire) cnt <= cnt + 6'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_job_ctrl.sv
// Bench for systolic_job_ctrl: table of jobs plus timeout and mid-job reset
// sequences, with an array stub and a matrix-multiply reference model.
`timescale 1ns/1ps
module tb_systolic_job_ctrl;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int TO = 64;

  typedef struct {
    int          a_mode;
    int          b_mode;
    int          in_pct;
    int          rdy_mode;
    bit          chk_corner;
    logic [AW-1:0] exp_c0;
    logic [AW-1:0] exp_c63;
    bit          exp_err;
  } job_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err, sa_start;
  logic sa_done = 1'b0;
  logic [2:0] dbg_state;
  logic [7:0][7:0][DW-1:0] sa_a, sa_b;
  logic [7:0][7:0][AW-1:0] sa_c = '0;

  systolic_job_ctrl_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

  systolic_job_ctrl #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy), .err(err),
    .sa_start(sa_start), .sa_A_matrix(sa_a), .sa_B_matrix(sa_b),
    .sa_C(sa_c), .sa_done(sa_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int a_w[64];
  int b_w[64];
  logic [AW-1:0] exp_q[$];
  job_t jobs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // array stub: behaves like a real array, multiplies whatever operands the DUT presents
  bit     stub_en = 1'b0;
  int     stub_delay = 0;
  int     stub_cnt = 0;
  int     done_cyc = -1;
  longint stub_acc;
  always @(negedge clk) begin
    if (!stub_en || !sa_start) begin
      sa_done  = 1'b0;
      stub_cnt = 0;
    end else if (!sa_done) begin
      if (stub_cnt >= stub_delay) begin
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++) begin
            stub_acc = 0;
            for (int k = 0; k < 8; k++)
              stub_acc += longint'($signed(sa_a[r][k])) * longint'($signed(sa_b[k][c]));
            sa_c[r][c] = AW'(stub_acc);
          end
        sa_done  = 1'b1;
        done_cyc = cyc;
      end else begin
        stub_cnt++;
      end
    end
  end

  function automatic int gen_word(input int mode, input int idx);
    logic [15:0] r;
    case (mode)
      0: return (idx / 8 == idx % 8) ? 1 : 0;
      1: return idx + 1;
      2: return 2;
      3: return 3;
      4: return -1;
      5: return -32768;
      default: begin
        r = 16'($urandom_range(0, 65535));
        return int'($signed(r));
      end
    endcase
  endfunction

  // reference model: C = A x B on plain integers, row-major into the expected queue
  task automatic build_model();
    longint s;
    exp_q.delete();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        s = 0;
        for (int k = 0; k < 8; k++) s += longint'(a_w[r*8+k]) * longint'(b_w[k*8+c]);
        exp_q.push_back(AW'(s));
      end
  endtask

  task automatic fill(input int a_mode, input int b_mode);
    for (int i = 0; i < 64; i++) begin
      a_w[i] = gen_word(a_mode, i);
      b_w[i] = gen_word(b_mode, i);
    end
  endtask

  // driver: returns at the first negedge after the n-th accepted word
  task automatic load_words(input int n, input int pct);
    int idx = 0;
    int guard = 0;
    bit v;
    while (idx < n && guard < 4000) begin
      @(negedge clk);
      guard++;
      v = ($urandom_range(0, 99) < pct);
      bus.in_valid = v;
      if (idx < 64) bus.in_data = DW'(a_w[idx]);
      else          bus.in_data = DW'(b_w[idx-64]);
      if (v && bus.in_ready) begin
        if (idx == 127) check("sa_start_low_before_last", sa_start, 0);
        if (idx == 0)   check("busy_idle_before_first", busy, 0);
        idx++;
      end
    end
    if (idx < n) check("load_timeout", idx, n);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_operands();
    int ma = 0;
    int mb = 0;
    for (int k = 0; k < 64; k++) begin
      if (sa_a[k/8][k%8] !== DW'(a_w[k])) ma++;
      if (sa_b[k/8][k%8] !== DW'(b_w[k])) mb++;
    end
    check("a_stored_mismatches", ma, 0);
    check("b_stored_mismatches", mb, 0);
  endtask

  task automatic wait_done();
    int guard = 0;
    while (!bus.out_valid && guard < 300) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = DW'($urandom);
      bus.out_ready = 1'b1;
      if (done_cyc >= 0 && cyc > done_cyc) check("sa_start_dropped", sa_start, 0);
      else                                 check("sa_start_held", sa_start, 1);
      @(negedge clk);
      guard++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("out_valid_arrives", bus.out_valid, 1);
    check("first_out_latency", cyc, done_cyc + 2);
  endtask

  // scoreboard for the result stream
  task automatic unload(input int rdy_mode, input bit chk_corner,
                        input logic [AW-1:0] c0, input logic [AW-1:0] c63);
    int j = 0;
    int k = 0;
    bit held = 1'b0;
    logic [AW-1:0] hd = '0;
    logic hl = 1'b0;
    bit r;
    logic [AW-1:0] e;
    while (j < 64 && k < 2000) begin
      if (!bus.out_valid) begin
        check("out_valid_gap", bus.out_valid, 1);
        break;
      end
      if (held) begin
        check("stall_data", bus.out_data, hd);
        check("stall_last", bus.out_last, hl);
      end
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = (k % 2 == 0);
        default: r = ($urandom_range(0, 1) == 1);
      endcase
      bus.out_ready = r;
      if (r) begin
        e = exp_q.pop_front();
        check("out_data", bus.out_data, e);
        check("out_last", bus.out_last, (j == 63));
        if (chk_corner && j == 0)  check("c_first", bus.out_data, c0);
        if (chk_corner && j == 63) check("c_last", bus.out_data, c63);
        j++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        hd = bus.out_data;
        hl = bus.out_last;
      end
      @(negedge clk);
      k++;
    end
    bus.out_ready = 1'b0;
    check("unload_count", j, 64);
    check("out_valid_after_last", bus.out_valid, 0);
    check("in_ready_after_last", bus.in_ready, 1);
    check("busy_after_last", busy, 0);
  endtask

  task automatic run_job(input job_t jb);
    fill(jb.a_mode, jb.b_mode);
    build_model();
    stub_en    = 1'b1;
    stub_delay = $urandom_range(0, 20);
    done_cyc   = -1;
    load_words(128, jb.in_pct);
    check("sa_start_rise", sa_start, 1);
    check("in_ready_run", bus.in_ready, 0);
    check("busy_run", busy, 1);
    check_operands();
    wait_done();
    unload(jb.rdy_mode, jb.chk_corner, jb.exp_c0, jb.exp_c63);
    check("err_after_job", err, jb.exp_err);
  endtask

  initial begin
    int nv;
    job_t extra;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    jobs[0] = '{0, 1, 100, 0, 1'b1, 32'd1,        32'd64,       1'b0};
    jobs[1] = '{2, 3, 100, 0, 1'b1, 32'd48,       32'd48,       1'b0};
    jobs[2] = '{0, 1, 100, 1, 1'b1, 32'd1,        32'd64,       1'b0};
    jobs[3] = '{4, 5,  50, 0, 1'b1, 32'h00040000, 32'h00040000, 1'b0};
    jobs[4] = '{6, 6,  70, 2, 1'b0, 32'd0,        32'd0,        1'b0};

    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_sa_start", sa_start, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_a_zero", |sa_a, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 5; i++) run_job(jobs[i]);

    // array never answers: watchdog must abort after TIMEOUT cycles in RUN
    fill(6, 6);
    stub_en = 1'b0;
    nv = 0;
    load_words(128, 100);
    repeat (TO - 1) begin
      if (bus.out_valid) nv++;
      @(negedge clk);
    end
    check("to_err_not_yet", err, 0);
    check("to_start_still_high", sa_start, 1);
    @(negedge clk);
    check("to_err_set", err, 1);
    check("to_start_dropped", sa_start, 0);
    check("to_no_out_valid", bus.out_valid, 0);
    @(negedge clk);
    check("to_back_idle", bus.in_ready, 1);
    check("to_busy_clear", busy, 0);
    check("to_never_valid", nv + int'(bus.out_valid), 0);

    extra = '{6, 6, 100, 0, 1'b0, 32'd0, 32'd0, 1'b1};
    run_job(extra);

    // reset in the middle of the B... of the A/B load (70 words in)
    fill(6, 6);
    load_words(70, 100);
    rst = 1'b1;
    #1;
    check("midrst_in_ready_low", bus.in_ready, 0);
    @(negedge clk);
    check("midrst_in_ready_held", bus.in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err_cleared", err, 0);
    check("midrst_a_cleared", |sa_a, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle_ready", bus.in_ready, 1);
    run_job(jobs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
